lcg_stream_checker: RTL

//  Receive-side checker for the LCG/CLCG pseudo-random stream. Samples each generator output,

---
 rtl/lcg_stream_checker_pkg.sv | 13 +
 rtl/lcg_next.sv | 18 +
 rtl/lcg_stream_checker.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/lcg_stream_checker_pkg.sv
// Shared definitions for the LCG stream checker: checker state encoding and
// the default stream width used by the generator side as well.
package lcg_stream_checker_pkg;

  localparam int LCG_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_LOCK = 2'd2
  } lcg_state_e;

endpackage

// File: rtl/lcg_next.sv
// One LCG step: y = (a*x + b) mod 2^W, built from the full 2W-bit product.
module lcg_next #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  logic [2*W-1:0] prod;
  logic           unused_prod_hi;

  assign prod           = {{W{1'b0}}, a} * {{W{1'b0}}, x};
  assign y              = prod[W-1:0] + b;
  assign unused_prod_hi = ^prod[2*W-1:W];

endmodule

// File: rtl/lcg_stream_checker.sv
// Receive-side LCG stream checker: locks after LOCK_N predicted samples, then
// counts mismatches and measures the sequence period.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | no reference sample yet; next accepted sample seeds x_prev
//   ST_SYNC | counting consecutive correct predictions toward LOCK_N
//   ST_LOCK | tracking; mismatches counted, period measured against ref
module lcg_stream_checker
  import lcg_stream_checker_pkg::*;
#(
  parameter int W      = LCG_W_DEF,
  parameter int CNT_W  = 16,
  parameter int LOCK_N = 2
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             clr,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             in_valid,
  input  logic [W-1:0]     in_x,
  output logic             locked,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] period,
  output logic             period_ok
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LOCK_TGT = CNT_W'(LOCK_N);

  lcg_state_e       state_q, state_nxt;
  logic [W-1:0]     x_prev_q, ref_q, ref_nxt;
  logic [W-1:0]     exp_x;
  logic             hit;
  logic [CNT_W-1:0] match_cnt_q, match_nxt, match_inc;
  logic [CNT_W-1:0] per_cnt_q, per_nxt;
  logic [CNT_W-1:0] err_nxt, period_nxt;
  logic             period_ok_nxt, mismatch_nxt;

  lcg_next #(.W(W)) u_next (
    .a (a),
    .b (b),
    .x (x_prev_q),
    .y (exp_x)
  );

  assign hit       = (in_x == exp_x);
  assign match_inc = match_cnt_q + CNT_ONE;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      x_prev_q    <= '0;
      ref_q       <= '0;
      match_cnt_q <= '0;
      per_cnt_q   <= '0;
      locked      <= 1'b0;
      mismatch    <= 1'b0;
      err_cnt     <= '0;
      period      <= '0;
      period_ok   <= 1'b0;
    end else if (clr) begin
      state_q     <= ST_IDLE;
      x_prev_q    <= '0;
      ref_q       <= '0;
      match_cnt_q <= '0;
      per_cnt_q   <= '0;
      locked      <= 1'b0;
      mismatch    <= 1'b0;
      err_cnt     <= '0;
      period      <= '0;
      period_ok   <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      if (in_valid) x_prev_q <= in_x;
      ref_q       <= ref_nxt;
      match_cnt_q <= match_nxt;
      per_cnt_q   <= per_nxt;
      locked      <= (state_nxt == ST_LOCK);
      mismatch    <= mismatch_nxt;
      err_cnt     <= err_nxt;
      period      <= period_nxt;
      period_ok   <= period_ok_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    if (in_valid) begin
      case (state_q)
        ST_IDLE: state_nxt = ST_SYNC;
        ST_SYNC: if (hit && (match_inc == LOCK_TGT)) state_nxt = ST_LOCK;
        ST_LOCK: if (!hit) state_nxt = ST_SYNC;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // mismatch is a pulse: it drops on the next edge whether or not a sample arrives
  always_comb begin
    ref_nxt       = ref_q;
    match_nxt     = match_cnt_q;
    per_nxt       = per_cnt_q;
    err_nxt       = err_cnt;
    period_nxt    = period;
    period_ok_nxt = period_ok;
    mismatch_nxt  = 1'b0;
    if (in_valid) begin
      case (state_q)
        ST_IDLE: match_nxt = '0;
        ST_SYNC: begin
          if (hit) begin
            match_nxt = match_inc;
            if (match_inc == LOCK_TGT) begin
              ref_nxt = in_x;
              per_nxt = '0;
            end
          end else begin
            match_nxt = '0;
          end
        end
        ST_LOCK: begin
          if (!hit) begin
            mismatch_nxt = 1'b1;
            match_nxt    = '0;
            if (err_cnt != CNT_MAX) err_nxt = err_cnt + CNT_ONE;
          end else if (in_x == ref_q) begin
            // a saturated count cannot represent the period; restart measuring
            if (per_cnt_q != CNT_MAX) begin
              period_nxt    = per_cnt_q + CNT_ONE;
              period_ok_nxt = 1'b1;
            end
            per_nxt = '0;
          end else if (per_cnt_q != CNT_MAX) begin
            per_nxt = per_cnt_q + CNT_ONE;
          end
        end
        default: match_nxt = '0;
      endcase
    end
  end

endmodule
